data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Memory-stage data memory that answers the pipelined CPU's load/store requests over a valid/ready handshake with a configurable number of wait states.
- Sits between the M stage of the CPU and a word-addressed storage array.
- Drives `stall` back to the hazard logic so the pipeline freezes until the access completes.
- Flags misaligned and out-of-range accesses instead of corrupting memory.

Parameters:
DEPTH_LOG2, 8, log2 of the number of 32-bit words (256 words, byte addresses 0x000–0x3FC).
WAIT_STATES, 2, extra cycles between request acceptance and response (0–15 legal).
DATA_WIDTH, 32, data word width; fixed at 32 for this core.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
req_valid  input  1  M stage has a load/store pending (MemWrite or MemToReg asserted in M).
req_write  input  1  1 = store, 0 = load.
req_addr  input  32  byte address (ALU result in M).
req_wdata  input  32  store data.
req_be  input  4  byte enables for stores; bit i covers bits [8i+7:8i]; ignored for loads.
req_ready  output  1  responder can accept a request this cycle.
resp_valid  output  1  one-cycle pulse: access complete.
resp_rdata  output  32  load data, valid while resp_valid.
resp_err  output  1  access was misaligned or out of range; valid with resp_valid.
stall  output  1  freeze F/D/E/M pipeline registers.

Behaviour:
- Reset (async, active-high):
  - state = IDLE, wait counter = 0, all latched request registers = 0.
  - req_ready = 1 (combinational from IDLE); resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - Storage array contents are not cleared by reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On a rising edge with req_valid = 1, latch write, addr, wdata and be.
  - Load the counter with WAIT_STATES.
  - Go to WAIT if WAIT_STATES > 0, else to RESP.
- WAIT:
  - req_ready = 0.
  - Decrement the counter each cycle.
  - When counter == 1 at a rising edge, go to RESP.
  - Result: exactly WAIT_STATES cycles are spent in WAIT.
- RESP (exactly one cycle):
  - resp_valid = 1; resp_rdata and resp_err are driven from registers captured on entry.
  - Next state is always IDLE.
  - In the RESP cycle, req_valid carries the same request; it must not be re-accepted.
- Latency: resp_valid asserts WAIT_STATES+1 cycles after the accepting edge.
- Store commit:
  - The array write happens on the edge entering RESP, only if resp_err will be 0.
  - Only bytes with req_be[i] = 1 are written.
  - req_be = 0000 still completes normally with no change to memory.
- Load data:
  - Captured on the edge entering RESP.
  - resp_rdata = 0 on error; for stores resp_rdata = 0.
- Error: resp_err = 1 when latched addr[1:0] != 0 or addr[31:DEPTH_LOG2+2] != 0. No write is performed.
- Stall:
  - stall = req_valid & ~resp_valid (combinational).
  - The pipeline advances on the RESP edge; the next cycle's req_valid belongs to the next instruction.
- Back-to-back requests: a new request is accepted in the IDLE cycle following RESP. Throughput is one access per WAIT_STATES+2 cycles.
- req_valid deasserting in WAIT/RESP (pipeline flush) does not abort the access. It completes and the response is ignored by the CPU.
- Reset mid-operation: pending access abandoned and no array write occurs; state returns to IDLE immediately.

Decomposition:
- Shared package:
  - State encoding: IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2.
  - Width constants: DATA_WIDTH, BE width.
  - Address-to-index function: addr[DEPTH_LOG2+1:2].
- One natural sub-module, mem_array_be:
  - Synchronous word-organised array with per-byte write enable and registered read port.
  - No reset on contents.
- FSM, counter and error check stay in the top module.

Test Plan:
- Store/load round trip, WAIT_STATES = 2: store 0xDEADBEEF to 0x010 with be = 1111, then load 0x010 -> each resp_valid arrives 3 cycles after acceptance; load returns 0xDEADBEEF with resp_err = 0; stall is high for 3 cycles of each access.
- Byte enables: preload 0x11223344 at 0x020, store 0xAABBCCDD with be = 0101 -> a subsequent load returns 0x11BB33DD.
- Errors: load 0x012 (misaligned) and store to 0x400 (out of range) -> resp_err = 1 and resp_rdata = 0; a later load of 0x000 shows memory unchanged.
- WAIT_STATES = 0, back-to-back: loads held continuously on req_valid -> resp_valid on every second cycle; req_ready is 0 in each RESP cycle; no double acceptance.
- Reset mid-operation: issue store 0x12345678 to 0x030, assert reset in WAIT -> outputs are 0 immediately; after release a load of 0x030 returns the old contents.
- Flush: deassert req_valid during WAIT -> resp_valid still pulses once and stall = 0 throughout the flushed cycles.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: FSM states, width
// constants and the byte-address to word-index mapping.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } stateT;

  localparam int DMEM_DATA_WIDTH = 32;
  localparam int DMEM_BE_WIDTH   = DMEM_DATA_WIDTH / 8;

  // Word index of a byte address; the caller truncates to its own depth.
  function automatic logic [31:0] addrToIndex(input logic [31:0] addr, input int depthLog2);
    logic [31:0] mask;
    mask = (32'd1 << depthLog2) - 32'd1;
    return (addr >> 2) & mask;
  endfunction

endpackage

// File: rtl/data_mem_responder_mem_array_be.sv
// Word-organised storage with per-byte write enables and a registered
// read port. Contents are deliberately not reset.
module mem_array_be #(
  parameter int DEPTH_LOG2 = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    writeEn,
  input  logic [DATA_WIDTH/8-1:0] byteEn,
  input  logic [DEPTH_LOG2-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Byte-masked write and read-before-write registered read of the same word
  always_ff @(posedge clk) begin
    if (writeEn) begin
      for (int i = 0; i < DATA_WIDTH/8; i++) begin
        if (byteEn[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// M-stage data memory responder: accepts one load/store over a
// valid/ready handshake, spends WAIT_STATES cycles waiting, then pulses
// a one-cycle response. Misaligned or out-of-range accesses are flagged
// and never touch the array.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 2,
  parameter int DATA_WIDTH  = data_mem_responder_pkg::DMEM_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic                    req_write,
  input  logic [31:0]             req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    req_ready,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic                    stall
);

  stateT state, nextState;
  logic [3:0]              waitCount;
  logic                    writeReg;
  logic [31:0]             addrReg;
  logic [DATA_WIDTH-1:0]   wdataReg;
  logic [DATA_WIDTH/8-1:0] beReg;
  logic                    errReg;

  logic                    srcWrite;
  logic [31:0]             srcAddr;
  logic [DATA_WIDTH-1:0]   srcWdata;
  logic [DATA_WIDTH/8-1:0] srcBe;
  logic                    srcErr;
  logic                    enterResp;
  logic                    memWriteEn;
  logic [DEPTH_LOG2-1:0]   memIdx;
  logic [DATA_WIDTH-1:0]   memRdata;

  // With zero wait states RESP is entered on the accepting edge itself,
  // before the latches hold the request, so the array sees the live inputs.
  assign srcWrite  = (state == IDLE) ? req_write : writeReg;
  assign srcAddr   = (state == IDLE) ? req_addr  : addrReg;
  assign srcWdata  = (state == IDLE) ? req_wdata : wdataReg;
  assign srcBe     = (state == IDLE) ? req_be    : beReg;
  assign srcErr    = (srcAddr[1:0] != 2'b00) || ((srcAddr >> (DEPTH_LOG2 + 2)) != 32'd0);
  assign enterResp = (nextState == RESP);
  assign memIdx    = DEPTH_LOG2'(addrToIndex(srcAddr, DEPTH_LOG2));
  assign memWriteEn = enterResp & srcWrite & ~srcErr & ~reset;

  mem_array_be #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .DATA_WIDTH(DATA_WIDTH)
  ) memArray (
    .clk    (clk),
    .writeEn(memWriteEn),
    .byteEn (srcBe),
    .addr   (memIdx),
    .wdata  (srcWdata),
    .rdata  (memRdata)
  );

  // State register, request latches, wait counter and error capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      waitCount <= 4'd0;
      writeReg  <= 1'b0;
      addrReg   <= 32'd0;
      wdataReg  <= '0;
      beReg     <= '0;
      errReg    <= 1'b0;
    end else begin
      state <= nextState;
      if (state == IDLE && req_valid) begin
        writeReg  <= req_write;
        addrReg   <= req_addr;
        wdataReg  <= req_wdata;
        beReg     <= req_be;
        waitCount <= 4'(WAIT_STATES);
      end else if (state == WAIT) begin
        waitCount <= waitCount - 4'd1;
      end
      if (enterResp) begin
        errReg <= srcErr;
      end
    end
  end

  // Next-state logic; RESP always lasts exactly one cycle
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (req_valid) nextState = (WAIT_STATES > 0) ? WAIT : RESP;
      WAIT: if (waitCount <= 4'd1) nextState = RESP;
      RESP: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid & errReg;
  assign resp_rdata = (resp_valid && !errReg && !writeReg) ? memRdata : '0;
  assign stall      = req_valid & ~resp_valid;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with two wait states and
// one with none, driven by directed and random accesses and compared
// against a word-array reference model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        reqValid  [2];
  logic        reqWrite  [2];
  logic [31:0] reqAddr   [2];
  logic [31:0] reqWdata  [2];
  logic [3:0]  reqBe     [2];
  logic        reqReady  [2];
  logic        respValid [2];
  logic [31:0] respRdata [2];
  logic        respErr   [2];
  logic        stall     [2];

  logic [31:0] refMem [2][256];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(2), .DATA_WIDTH(32)) dut2 (
    .clk(clk), .reset(reset),
    .req_valid(reqValid[0]), .req_write(reqWrite[0]), .req_addr(reqAddr[0]),
    .req_wdata(reqWdata[0]), .req_be(reqBe[0]), .req_ready(reqReady[0]),
    .resp_valid(respValid[0]), .resp_rdata(respRdata[0]), .resp_err(respErr[0]),
    .stall(stall[0])
  );

  data_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(0), .DATA_WIDTH(32)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(reqValid[1]), .req_write(reqWrite[1]), .req_addr(reqAddr[1]),
    .req_wdata(reqWdata[1]), .req_be(reqBe[1]), .req_ready(reqReady[1]),
    .resp_valid(respValid[1]), .resp_rdata(respRdata[1]), .resp_err(respErr[1]),
    .stall(stall[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One full access. hold keeps req_valid high while waiting (0 = flush);
  // keep leaves req_valid high after the response for back-to-back use.
  task automatic applyStimulus(input int u, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input bit hold, input bit keep);
    int ws;
    int cyc;
    bit err;
    int idx;
    logic [31:0] expData;
    ws = (u == 0) ? 2 : 0;
    @(negedge clk);
    reqValid[u] = 1'b1;
    reqWrite[u] = wr;
    reqAddr[u]  = addr;
    reqWdata[u] = wdata;
    reqBe[u]    = be;
    #1;
    checkOutput("ready_idle", 32'(reqReady[u]), 32'd1);
    checkOutput("stall_accept", 32'(stall[u]), 32'd1);
    checkOutput("noresp_idle", 32'(respValid[u]), 32'd0);
    for (cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (!hold) reqValid[u] = 1'b0;
      #1;
      if (respValid[u]) break;
      checkOutput("stall_wait", 32'(stall[u]), 32'(hold));
      checkOutput("ready_wait", 32'(reqReady[u]), 32'd0);
    end
    checkOutput("latency", 32'(cyc), 32'(ws + 1));
    err = (addr[1:0] != 2'b00) || (addr > 32'h3FF);
    idx = int'(addr[9:2]);
    expData = (!err && !wr) ? refMem[u][idx] : 32'd0;
    checkOutput("resp_err", 32'(respErr[u]), 32'(err));
    checkOutput("resp_rdata", respRdata[u], expData);
    checkOutput("ready_resp", 32'(reqReady[u]), 32'd0);
    checkOutput("stall_resp", 32'(stall[u]), 32'd0);
    if (!err && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) refMem[u][idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    if (!keep) reqValid[u] = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    for (int u = 0; u < 2; u++) begin
      reqValid[u] = 1'b0; reqWrite[u] = 1'b0; reqAddr[u] = 32'd0;
      reqWdata[u] = 32'd0; reqBe[u] = 4'd0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      checkOutput("rst_ready", 32'(reqReady[u]), 32'd1);
      checkOutput("rst_valid", 32'(respValid[u]), 32'd0);
      checkOutput("rst_rdata", respRdata[u], 32'd0);
      checkOutput("rst_err", 32'(respErr[u]), 32'd0);
      checkOutput("rst_stall", 32'(stall[u]), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Preload the first 16 words of both arrays with known data
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 16; i++)
        applyStimulus(u, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b1, 1'b0);

    // Store/load round trip
    applyStimulus(0, 1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 32'h010, 32'd0, 4'h0, 1'b1, 1'b0);

    // Byte enables merge into existing word, and empty enables change nothing
    applyStimulus(0, 1'b1, 32'h020, 32'h11223344, 4'hF, 1'b1, 1'b0);
    applyStimulus(0, 1'b1, 32'h020, 32'hAABBCCDD, 4'b0101, 1'b1, 1'b0);
    applyStimulus(0, 1'b1, 32'h020, 32'h55555555, 4'b0000, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 32'h020, 32'd0, 4'h0, 1'b1, 1'b0);

    // Misaligned load, out-of-range store, then memory is untouched
    applyStimulus(0, 1'b0, 32'h012, 32'd0, 4'h0, 1'b1, 1'b0);
    applyStimulus(0, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0);
    applyStimulus(0, 1'b1, 32'h003, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 32'h000, 32'd0, 4'h0, 1'b1, 1'b0);

    // Reset during WAIT abandons the store
    @(negedge clk);
    reqValid[0] = 1'b1; reqWrite[0] = 1'b1; reqAddr[0] = 32'h030;
    reqWdata[0] = 32'h12345678; reqBe[0] = 4'hF;
    @(negedge clk);
    reqValid[0] = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("midrst_valid", 32'(respValid[0]), 32'd0);
    checkOutput("midrst_rdata", respRdata[0], 32'd0);
    checkOutput("midrst_err", 32'(respErr[0]), 32'd0);
    checkOutput("midrst_ready", 32'(reqReady[0]), 32'd1);
    checkOutput("midrst_stall", 32'(stall[0]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 1'b0, 32'h030, 32'd0, 4'h0, 1'b1, 1'b0);

    // Flushed access still completes with exactly one response
    applyStimulus(0, 1'b1, 32'h014, 32'h0BADF00D, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("flush_single", 32'(respValid[0]), 32'd0);
    applyStimulus(0, 1'b0, 32'h014, 32'd0, 4'h0, 1'b1, 1'b0);

    // Zero-wait back-to-back loads with req_valid held continuously
    for (int k = 0; k < 6; k++)
      applyStimulus(1, 1'b0, 32'(k * 4), 32'd0, 4'h0, 1'b1, 1'b1);
    reqValid[1] = 1'b0;

    // Random mix of loads, stores, misaligned and out-of-range accesses
    for (int u = 0; u < 2; u++) begin
      for (int n = 0; n < 30; n++) begin
        a = 32'($urandom_range(0, 15)) << 2;
        case ($urandom_range(0, 7))
          0: a = a | 32'($urandom_range(1, 3));
          1: a = 32'h400 | ($urandom & 32'hFFFF_FFFC);
          default: ;
        endcase
        applyStimulus(u, 1'($urandom_range(0, 1)), a, $urandom,
                      4'($urandom_range(0, 15)), 1'b1, 1'b0);
      end
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
